// File: rtl/dac_ramp_envelope.sv
// dac_ramp_envelope: soft start/stop stage that scales the signed DAC stream by a
// linear amplitude envelope (0 -> unity -> 0) that follows an enable level.
// Optional output offset stage is built when DAC_OFFSET_EN is defined.
module dac_ramp_envelope #(
    parameter int unsigned ENV_WIDTH  = 15,
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic signed [DATA_WIDTH-1:0] dac_in,
    input  logic                         enable,
    input  logic        [ENV_WIDTH-1:0]  cfg_step,
`ifdef DAC_OFFSET_EN
    input  logic signed [DATA_WIDTH-1:0] cfg_offset,
`endif
    output logic signed [DATA_WIDTH-1:0] dac_out,
    output logic        [1:0]            ramp_state,
    output logic                         ramp_done
);

    localparam int unsigned SUM_W  = ENV_WIDTH + 1;
    localparam int unsigned PROD_W = DATA_WIDTH + ENV_WIDTH + 1;
    localparam int unsigned SHIFT  = ENV_WIDTH - 1;
    localparam int unsigned UNITY  = 1 << (ENV_WIDTH - 1);

    localparam logic [ENV_WIDTH-1:0] ENV_UNITY = ENV_WIDTH'(UNITY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_HOLD      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t                       r_state;
    logic   [ENV_WIDTH-1:0]       r_env;
    logic                         r_done;
    logic signed [DATA_WIDTH-1:0] r_s1_data;
    logic   [ENV_WIDTH-1:0]       r_s1_env;
    logic signed [DATA_WIDTH-1:0] r_s2_data;

    state_t                       w_state_nxt;
    logic   [ENV_WIDTH-1:0]       w_env_nxt;
    logic                         w_done_nxt;
    logic   [SUM_W-1:0]           w_up_sum;
    logic   [ENV_WIDTH-1:0]       w_env_up;
    logic   [ENV_WIDTH-1:0]       w_env_dn;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [DATA_WIDTH-1:0] w_scaled;

    // Saturating envelope candidates; the sum is one bit wider so it never wraps
    assign w_up_sum = SUM_W'(r_env) + SUM_W'(cfg_step);
    assign w_env_up = (w_up_sum >= SUM_W'(UNITY)) ? ENV_UNITY : w_up_sum[ENV_WIDTH-1:0];
    assign w_env_dn = (r_env <= cfg_step) ? '0 : (r_env - cfg_step);

    // FSM state and envelope register
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_env   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_env   <= w_env_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state / envelope; every move applies one step from the current envelope
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_done_nxt  = 1'b0;
        if (cfg_step == '0) begin
            if (enable) begin
                w_state_nxt = S_HOLD;
                w_env_nxt   = ENV_UNITY;
            end else begin
                w_state_nxt = S_IDLE;
                w_env_nxt   = '0;
            end
        end else if (enable) begin
            if (r_state == S_HOLD) begin
                w_env_nxt = ENV_UNITY;
            end else begin
                w_env_nxt = w_env_up;
                if (w_env_up == ENV_UNITY) begin
                    w_state_nxt = S_HOLD;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_RAMP_UP;
                end
            end
        end else begin
            if (r_state == S_IDLE) begin
                w_env_nxt = '0;
            end else begin
                w_env_nxt = w_env_dn;
                if (w_env_dn == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
        end
    end

    // Gain |env/unity| <= 1, so the floored product always fits the sample width
    assign w_prod   = PROD_W'(r_s1_data) * PROD_W'($signed({1'b0, r_s1_env}));
    assign w_scaled = DATA_WIDTH'(w_prod >>> SHIFT);

    // Stage 1 pairs each sample with the envelope of its cycle; stage 2 holds the scaled sample
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_s1_data <= '0;
            r_s1_env  <= '0;
            r_s2_data <= '0;
        end else begin
            r_s1_data <= dac_in;
            r_s1_env  <= r_env;
            r_s2_data <= w_scaled;
        end
    end

`ifdef DAC_OFFSET_EN
    localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH + 1)'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = -SAT_MAX - (DATA_WIDTH + 1)'(1);

    logic signed [DATA_WIDTH:0]   w_off_sum;
    logic signed [DATA_WIDTH-1:0] r_s3_data;

    assign w_off_sum = (DATA_WIDTH + 1)'(r_s2_data) + (DATA_WIDTH + 1)'(cfg_offset);

    // Stage 3: add offset and saturate back to the DAC range
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_s3_data <= '0;
        end else if (w_off_sum > SAT_MAX) begin
            r_s3_data <= DATA_WIDTH'(SAT_MAX);
        end else if (w_off_sum < SAT_MIN) begin
            r_s3_data <= DATA_WIDTH'(SAT_MIN);
        end else begin
            r_s3_data <= DATA_WIDTH'(w_off_sum);
        end
    end

    assign dac_out = r_s3_data;
`else
    assign dac_out = r_s2_data;
`endif

    assign ramp_state = r_state;
    assign ramp_done  = r_done;

endmodule

// File: tb/tb_dac_ramp_envelope.sv
// tb_dac_ramp_envelope: directed and random stimulus with an envelope model and an
// output scoreboard for dac_ramp_envelope (works with or without DAC_OFFSET_EN).
module tb_dac_ramp_envelope;

`ifdef DAC_OFFSET_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int UNITY = 16384;

    logic               clk = 1'b0;
    logic               aresetn;
    logic signed [13:0] dac_in;
    logic               enable;
    logic [14:0]        cfg_step;
    logic signed [13:0] cfg_offset;
    logic signed [13:0] dac_out;
    logic [1:0]         ramp_state;
    logic               ramp_done;

    int checks = 0;
    int errors = 0;
    int m_env, m_state, m_done;
    int q[$];
    int done_cnt;
    int off_now;

    always #5 clk = ~clk;

    dac_ramp_envelope dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .dac_in     (dac_in),
        .enable     (enable),
        .cfg_step   (cfg_step),
`ifdef DAC_OFFSET_EN
        .cfg_offset (cfg_offset),
`endif
        .dac_out    (dac_out),
        .ramp_state (ramp_state),
        .ramp_done  (ramp_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scale(input int d, input int env);
        longint p;
        p = longint'(d) * longint'(env);
        return int'(p >>> 14);
    endfunction

    function automatic int sat14(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    task automatic model_reset();
        m_env = 0; m_state = 0; m_done = 0;
        q.delete();
    endtask

    // Reference envelope behaviour for one clock
    task automatic model_update(input bit en, input int stp);
        int prev;
        prev = m_state;
        m_done = 0;
        if (stp == 0) begin
            m_env   = en ? UNITY : 0;
            m_state = en ? 2 : 0;
        end else if (en) begin
            if (prev != 2) begin
                m_env = (m_env + stp > UNITY) ? UNITY : m_env + stp;
                if (m_env == UNITY) begin m_state = 2; m_done = 1; end
                else m_state = 1;
            end
        end else begin
            if (prev != 0) begin
                m_env = (m_env - stp < 0) ? 0 : m_env - stp;
                if (m_env == 0) begin m_state = 0; m_done = 1; end
                else m_state = 3;
            end
        end
    endtask

    // One clock: push expected for the current sample, advance, compare
    task automatic step();
        int e;
        q.push_back(scale(int'(dac_in), m_env));
        off_now = int'(cfg_offset);
        @(posedge clk); #1;
        model_update(enable, int'(cfg_step));
        chk("ramp_state", int'(ramp_state), m_state);
        chk("ramp_done", int'(ramp_done), m_done);
        if (ramp_done) done_cnt++;
        if (q.size() == LAT) begin
            e = q.pop_front();
`ifdef DAC_OFFSET_EN
            e = sat14(e + off_now);
`endif
            chk("dac_out", int'(dac_out), e);
        end
    endtask

    initial begin
        int exp_up[4];
        exp_up[0] = 2047; exp_up[1] = 4095; exp_up[2] = 6143; exp_up[3] = 8191;

        // Reset with active-looking inputs
        aresetn = 1'b0; dac_in = 14'sd8191; enable = 1'b1; cfg_step = 15'd4096; cfg_offset = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_dac_out", int'(dac_out), 0);
        chk("reset_state", int'(ramp_state), 0);
        chk("reset_done", int'(ramp_done), 0);
        aresetn = 1'b1;
        model_reset();

        // Ramp up with step 4096
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 3) chk("hold_after_4", int'(ramp_state), 2);
            if (i >= LAT && i < LAT + 4) chk("ramp_up_out", int'(dac_out), exp_up[i-LAT]);
        end
        chk("ramp_up_done_cnt", done_cnt, 1);

        // Ramp down to 8192 then reset mid-ramp
        enable = 1'b0;
        step(); step();
        chk("ramp_down_state", int'(ramp_state), 3);
        aresetn = 1'b0;
        @(posedge clk); #1;
        chk("midreset_state", int'(ramp_state), 0);
        chk("midreset_done", int'(ramp_done), 0);
        chk("midreset_dac_out", int'(dac_out), 0);
        aresetn = 1'b1;
        model_reset();
        step();

        // Clamp on oversize step, then immediate reversal
        done_cnt = 0;
        cfg_step = 15'd10000; enable = 1'b1; dac_in = 14'sd5000;
        step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dac_in = 14'($urandom);
            step();
        end
        chk("reversal_done_cnt", done_cnt, 1);
        chk("reversal_state", int'(ramp_state), 0);

        // Most negative sample at full scale
        cfg_step = '0; enable = 1'b1; dac_in = -14'sd8192;
        repeat (LAT + 1) step();
        chk("full_scale_neg", int'(dac_out), -8192);

        // Bypass: enable 0 -> 1 -> 0 with step 0
        done_cnt = 0;
        enable = 1'b0; dac_in = 14'sd1234;
        repeat (3) step();
        enable = 1'b1;
        repeat (LAT + 1) step();
        chk("bypass_hold_state", int'(ramp_state), 2);
        chk("bypass_pass", int'(dac_out), 1234);
        enable = 1'b0;
        repeat (LAT + 1) step();
        chk("bypass_idle_state", int'(ramp_state), 0);
        chk("bypass_idle_out", int'(dac_out), 0);
        chk("bypass_done_cnt", done_cnt, 0);

        // Random enable toggling, step sizes and samples
        for (int i = 0; i < 400; i++) begin
            int sel;
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) begin
                sel = int'($urandom_range(0, 6));
                case (sel)
                    0: cfg_step = 15'd0;
                    1: cfg_step = 15'd1;
                    2: cfg_step = 15'd100;
                    3: cfg_step = 15'd4096;
                    4: cfg_step = 15'd10000;
                    5: cfg_step = 15'd20000;
                    default: cfg_step = 15'd32767;
                endcase
            end
            dac_in = 14'($urandom);
            step();
        end

`ifdef DAC_OFFSET_EN
        // Offset saturation in HOLD and offset visible in IDLE
        cfg_step = '0; enable = 1'b1; dac_in = 14'sd8000; cfg_offset = 14'sd500;
        repeat (LAT + 2) step();
        chk("offset_sat", int'(dac_out), 8191);
        enable = 1'b0; cfg_offset = -14'sd100;
        repeat (LAT + 2) step();
        chk("offset_idle", int'(dac_out), -100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
